// File: rtl/iob_timer_sampler_pkg.sv
// Shared definitions for iob_timer_sampler: FSM state encoding, default
// timer register map and the value written to the timer's command registers.
package iob_timer_sampler_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 4'd0,
        RST_W    = 4'd1,
        RST_GAP  = 4'd2,
        STOP_W   = 4'd3,
        STOP_GAP = 4'd4,
        RD_HI    = 4'd5,
        HI_GAP   = 4'd6,
        RD_LO    = 4'd7,
        DONE     = 4'd8
    } state_t;

    // Timer slave register map
    localparam int DEF_RESET_ADDR = 0;
    localparam int DEF_STOP_ADDR  = 1;
    localparam int DEF_HIGH_ADDR  = 2;
    localparam int DEF_LOW_ADDR   = 3;

    // Command registers are triggered by writing a single 1
    localparam int WR_DATA = 1;

endpackage

// File: rtl/iob_timer_sampler_tick.sv
// Free-running period counter for iob_timer_sampler; raises a one-cycle tick
// every `period` cycles. Only instantiated with IOB_TIMER_SAMPLER_PERIODIC_EN.
module iob_timer_sampler_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] cnt_q;

    // Using >= lets a shortened period take effect at once instead of waiting for a counter wrap
    assign tick = (period != 32'd0) && (cnt_q >= period - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else if ((period == 32'd0) || tick) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/iob_timer_sampler.sv
// iob_timer_sampler: native-bus initiator that soft-resets or snapshots a timer
// and reads back its 64-bit count. Define IOB_TIMER_SAMPLER_PERIODIC_EN for auto-sampling.
module iob_timer_sampler
    import iob_timer_sampler_pkg::*;
#(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 32,
    parameter int RESET_ADDR = DEF_RESET_ADDR,
    parameter int STOP_ADDR  = DEF_STOP_ADDR,
    parameter int HIGH_ADDR  = DEF_HIGH_ADDR,
    parameter int LOW_ADDR   = DEF_LOW_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef IOB_TIMER_SAMPLER_PERIODIC_EN
    input  logic [31:0]           period,
`endif
    input  logic                  sample_req,
    input  logic                  reset_req,
    output logic                  busy,
    output logic [2*DATA_W-1:0]   sample,
    output logic                  sample_valid,
    output logic                  valid,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  ready
);

    state_t              state_q, state_d;
    logic                pend_rst_q, pend_smp_q;
    logic [DATA_W-1:0]   hi_q;
    logic                auto_req;
    logic                rst_any, smp_any, take_rst, take_smp;
    logic                bus_valid_d, bus_write_d;
    logic [ADDR_W-1:0]   bus_addr_d;

`ifdef IOB_TIMER_SAMPLER_PERIODIC_EN
    iob_timer_sampler_tick u_tick (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .tick   (auto_req)
    );
`else
    assign auto_req = 1'b0;
`endif

    // Live requests and parked requests are treated alike; a flag clears only when its sequence starts
    assign rst_any  = reset_req | pend_rst_q;
    assign smp_any  = sample_req | auto_req | pend_smp_q;
    assign take_rst = (state_q == IDLE) && rst_any;
    assign take_smp = (state_q == IDLE) && !rst_any && smp_any;
    assign busy     = (state_q != IDLE) | pend_rst_q | pend_smp_q;

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (rst_any) state_d = RST_W;
                      else if (smp_any) state_d = STOP_W;
            RST_W:    if (ready) state_d = RST_GAP;
            RST_GAP:  state_d = IDLE;
            STOP_W:   if (ready) state_d = STOP_GAP;
            STOP_GAP: state_d = RD_HI;
            RD_HI:    if (ready) state_d = HI_GAP;
            HI_GAP:   state_d = RD_LO;
            RD_LO:    if (ready) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bus fields are decoded from the next state so they can be registered glitch-free
    always_comb begin
        bus_valid_d = 1'b0;
        bus_write_d = 1'b0;
        bus_addr_d  = '0;
        case (state_d)
            RST_W: begin
                bus_valid_d = 1'b1;
                bus_write_d = 1'b1;
                bus_addr_d  = ADDR_W'(RESET_ADDR);
            end
            STOP_W: begin
                bus_valid_d = 1'b1;
                bus_write_d = 1'b1;
                bus_addr_d  = ADDR_W'(STOP_ADDR);
            end
            RD_HI: begin
                bus_valid_d = 1'b1;
                bus_addr_d  = ADDR_W'(HIGH_ADDR);
            end
            RD_LO: begin
                bus_valid_d = 1'b1;
                bus_addr_d  = ADDR_W'(LOW_ADDR);
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so sample reads 0 until the first readout.
            state_q      <= IDLE;
            pend_rst_q   <= 1'b0;
            pend_smp_q   <= 1'b0;
            valid        <= 1'b0;
            address      <= '0;
            wdata        <= '0;
            wstrb        <= '0;
            hi_q         <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_rst_q   <= rst_any & ~take_rst;
            pend_smp_q   <= smp_any & ~take_smp;
            valid        <= bus_valid_d;
            address      <= bus_addr_d;
            wdata        <= bus_write_d ? DATA_W'(WR_DATA) : '0;
            wstrb        <= bus_write_d ? '1 : '0;
            sample_valid <= (state_q == RD_LO) && ready;
            if ((state_q == RD_HI) && ready) begin
                hi_q <= rdata;
            end
            if ((state_q == RD_LO) && ready) begin
                sample <= {hi_q, rdata};
            end
        end
    end

endmodule

// File: doc/iob_timer_sampler.md
Name: iob_timer_sampler

Overview:
- Native-bus initiator that drives the CPU native slave port of a timer peripheral: soft-reset, snapshot-latch, then 64-bit readout.
- Sits beside the timer in an SoC subsystem, for example a trace or event-timestamp unit.
- Converts single-cycle request pulses into complete bus transaction sequences.
- Presents the assembled 64-bit count with a one-cycle valid strobe.

Parameters:
- ADDR_W, 2, native-bus address width.
- DATA_W, 32, native-bus data width. 64-bit sample = 2*DATA_W.
- RESET_ADDR, 0, timer soft-reset register address.
- STOP_ADDR, 1, timer snapshot-latch register address.
- HIGH_ADDR, 2, snapshot upper-word address.
- LOW_ADDR, 3, snapshot lower-word address.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_req  in  1  pulse: request a timer snapshot.
- reset_req  in  1  pulse: request a timer soft reset.
- busy  out  1  high while any sequence is in progress.
- sample  out  2*DATA_W  last assembled timer value.
- sample_valid  out  1  one-cycle strobe when `sample` updates.
- valid  out  1  native-bus request.
- address  out  ADDR_W  native-bus address.
- wdata  out  DATA_W  native-bus write data.
- wstrb  out  DATA_W/8  native-bus byte strobes (0 = read).
- rdata  in  DATA_W  native-bus read data.
- ready  in  1  native-bus completion, one-cycle pulse.

Behaviour:
- Reset values: valid=0, address=0, wdata=0, wstrb=0, sample=0, sample_valid=0, busy=0, FSM=IDLE, pending flags=0.
- FSM states: IDLE, RST_W, RST_GAP, STOP_W, STOP_GAP, RD_HI, HI_GAP, RD_LO, DONE.
- Bus rule: valid, address, wdata and wstrb are registered and held constant from assertion until ready is sampled high. valid is 0 in the cycle after ready (GAP/DONE states). No back-to-back valid.
- Writes: wdata={DATA_W-1 zeros,1'b1}, wstrb all ones.
- Reads: wdata=0, wstrb=0. rdata is captured on the cycle ready=1.
- IDLE: if reset_req or the pending reset flag is set, go to RST_W. Else if sample_req or the pending sample flag is set, go to STOP_W. Reset has priority when both are present.
- Reset sequence: RST_W (write RESET_ADDR) -> on ready -> RST_GAP -> IDLE.
- Sample sequence:
  - STOP_W (write STOP_ADDR) -> on ready -> STOP_GAP.
  - RD_HI (read HIGH_ADDR, capture into hi) -> on ready -> HI_GAP.
  - RD_LO (read LOW_ADDR) -> on ready -> DONE.
  - DONE: sample <= {hi, rdata_lo}, sample_valid=1 for exactly one cycle, return to IDLE.
- Latency against a responder with 1-cycle ready (request seen in cycle 0):
  - STOP valid in cycles 1-2, RD_HI valid in cycles 4-5, RD_LO valid in cycles 7-8.
  - sample_valid in cycle 9.
  - Back-to-back sample sequences start at most every 10 cycles.
- Requests while busy: set a one-deep pending flag per request type. Repeats while the flag is set are merged, not counted. A flag is cleared when its sequence leaves IDLE.
- A request arriving in the same cycle the FSM returns to IDLE is not lost.
- busy = (state != IDLE) | any pending flag.
- sample holds its value until the next DONE. It is unaffected by reset sequences.
- Responder stall: valid is held indefinitely. There is no timeout.
- rst asserted mid-transaction: valid drops asynchronously, all state is cleared, and no sample_valid is produced.

Optional Feature:
- Macro: IOB_TIMER_SAMPLER_PERIODIC_EN.
- Defined:
  - Adds input `period` (32 bits) and a 32-bit free-running tick counter.
  - When period != 0, the counter increments every cycle. On reaching period-1 it wraps to 0 and raises an internal request, ORed with sample_req (merged into pending if busy).
  - When period == 0, the counter is held at 0 and no auto requests are raised.
  - A change of period takes effect on the next compare. If the counter is already ≥ the new period-1, the compare matches and the counter wraps.
- Undefined: no port, no counter, manual requests only.

Decomposition:
- Header iob_timer_sampler.vh:
  - FSM state encodings and state width.
  - Default register address constants.
  - Write-data constant.
- Sub-module iob_timer_sampler_tick: the periodic counter/comparator. Instantiated only under IOB_TIMER_SAMPLER_PERIODIC_EN.

Test Plan:
- Responder model (ready 1 cycle after valid) holding snapshot 0x00000001_DEADBEEF; sample_req pulse at cycle 0 -> writes to STOP_ADDR, reads HIGH_ADDR then LOW_ADDR; sample=0x00000001DEADBEEF with sample_valid at cycle 9 only; valid low at cycles 3, 6, 9.
- reset_req and sample_req in the same cycle -> RESET_ADDR write with wdata=1, wstrb=0xF first, then the full sample sequence; busy stays high throughout.
- Slow responder (ready 4 cycles after valid) -> address and wstrb stable for all 4 cycles; sample_valid at cycle 18.
- Three sample_req pulses during one sequence -> exactly one extra sequence; total of two sample_valid strobes.
- rst asserted while RD_HI valid=1 -> valid=0 immediately; sample remains 0 after reset; no sample_valid.
- Periodic build, period=20, idle requests -> sample_valid every 20 cycles. period=0 -> no bus activity over 100 cycles.
